button_debounce_pulse: RTL and testbench
========================================

Name: button_debounce_pulse

Overview:
Debounces one raw push-button or switch input on the FPGA board and emits a single-cycle, clean toggle request for the LC-3 front panel. It is the stage directly upstream of the negedge toggle flip-flop (D/WE inputs): Pulse drives D, with WE tied high or gated by the CPU. All logic is posedge Clk, so Pulse is stable across the following negedge, where the toggle stage samples it.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronized cycles of a level required to accept a press or release (must be >= 2)
CNT_W, 5, counter width; must satisfy 2^CNT_W >= max(DEBOUNCE_CYCLES, REPEAT_CYCLES)
REPEAT_CYCLES, 24, auto-repeat period; used only when BTN_AUTO_REPEAT_EN is defined

Ports:
Clk  input  1  system clock, posedge
Reset  input  1  synchronous, active-high reset
Btn_Async  input  1  raw button level, asynchronous, 1 = pressed
Pulse  output  1  one-cycle registered toggle request per accepted press
Stable  output  1  registered debounced button level

Behaviour:
- Reset (synchronous, active-high): sync flops = 0, cnt = 0, state = RELEASE_WAIT, Pulse = 0, Stable = 0.
- The RELEASE_WAIT reset state means a button held through reset never produces a Pulse.
- Btn_Async passes through a 2-flop synchronizer; sync_in is the second flop.
- States: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT (2-bit encoding).
- IDLE:
  - sync_in = 1 -> PRESS_WAIT, cnt = 0.
  - Otherwise stay.
- PRESS_WAIT:
  - sync_in = 0 -> IDLE, cnt = 0 (bounce rejected, no Pulse).
  - cnt == DEBOUNCE_CYCLES-1 -> PRESSED, Pulse = 1 for that cycle only, Stable = 1.
  - Otherwise cnt + 1.
- PRESSED:
  - sync_in = 0 -> RELEASE_WAIT, cnt = 0.
  - Otherwise stay; Pulse = 0.
- RELEASE_WAIT:
  - sync_in = 1 -> PRESSED, cnt = 0, Stable = 1, no Pulse (release bounce rejected).
  - cnt == DEBOUNCE_CYCLES-1 -> IDLE, Stable = 0.
  - Otherwise cnt + 1.
- Latency: Btn_Async stable high from sampling edge 1 -> Pulse high after edge DEBOUNCE_CYCLES+3 (edge 7 when DEBOUNCE_CYCLES = 4).
- Release latency is the same, measured to Stable falling.
- Pulse is never high in two consecutive cycles (except auto-repeat, which is also single-cycle and spaced).
- At most one Pulse per accepted press.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset asserted in any state overrides every transition that cycle; a Pulse in flight is cleared.

Optional Feature:
BTN_AUTO_REPEAT_EN
- Defined: a second counter rcnt counts in PRESSED, reset to 0 on entry.
  - When rcnt == REPEAT_CYCLES-1, Pulse = 1 for one cycle and rcnt = 0.
  - Repeats until the button leaves PRESSED.
  - rcnt is cleared on reset and on entry to RELEASE_WAIT.
- Undefined: no rcnt and exactly one Pulse per press; REPEAT_CYCLES is ignored.

Decomposition:
- Package btn_pkg holds:
  - state localparams ST_IDLE = 0, ST_PRESS_WAIT = 1, ST_PRESSED = 2, ST_RELEASE_WAIT = 3
  - the state width constant
- Sub-module sync_2ff (Clk, Reset, D, Q): 2-stage synchronizer, synchronous reset to 0, reusable for other board inputs.

Test Plan:
1. DEBOUNCE_CYCLES = 4; Reset 2 cycles, then Btn_Async = 1 held -> Pulse high exactly during the cycle after edge 7; Stable = 1 from edge 7; Pulse low afterwards.
2. Bounce on press: Btn_Async 1,0,1,0 alternating every cycle for 10 cycles, then 0 -> Pulse never asserts; state returns to IDLE.
3. Bounce on release: after an accepted press, Btn_Async 0 for 2 cycles then 1 -> Stable stays 1, no second Pulse.
4. Held through reset: Btn_Async = 1 before and during Reset, then Reset released -> no Pulse; Stable = 1 after 3 edges; after release, Stable = 0 at edge 7.
5. Reset mid-PRESS_WAIT (cnt = 2), released with button held -> no Pulse, Stable = 0 at reset.
6. BTN_AUTO_REPEAT_EN defined, REPEAT_CYCLES = 8, DEBOUNCE_CYCLES = 4, button held 30 cycles -> Pulses at cycles 7, 15, 23, 31 relative to first sampling edge.

Source files
------------

// File: rtl/button_debounce_pulse_pkg.sv
// Shared constants for the front-panel button debouncer: FSM state encoding and
// a small elaboration-time helper for checking the counter width.
package btn_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE         = 2'd0;
  localparam logic [STATE_W-1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PRESSED      = 2'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE_WAIT = 2'd3;

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_pulse_if.sv
// Button-side signal bundle: raw level in, toggle pulse and debounced level out,
// plus the FSM state for observation.
interface button_debounce_pulse_if;

  // Level-based, no handshake: Btn_Async may change at any time, and Pulse and
  // Stable are registered on the Clk posedge.
  logic                       Btn_Async;
  logic                       Pulse;
  logic                       Stable;
  logic [btn_pkg::STATE_W-1:0] dbg_state;

  modport master (output Btn_Async, input Pulse, input Stable, input dbg_state);
  modport slave  (input Btn_Async, output Pulse, output Stable, output dbg_state);

endinterface

// File: rtl/button_debounce_pulse_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; Q is the second stage.
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// Debounces one push-button and emits a one-cycle toggle request per accepted press.
// Define BTN_AUTO_REPEAT_EN to add a periodic repeat Pulse while the button is held.
module button_debounce_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int REPEAT_CYCLES   = 24
) (
  input  logic                    Clk,
  input  logic                    Reset,
  button_debounce_pulse_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 2 ||
      (2 ** CNT_W) < btn_max(DEBOUNCE_CYCLES, REPEAT_CYCLES)) begin : g_bad_cfg
    $error("button_debounce_pulse: DEBOUNCE_CYCLES/CNT_W/REPEAT_CYCLES inconsistent");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic               sync_in;
  logic [STATE_W-1:0] state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               pulse_q, pulse_nxt;
  logic               stable_q, stable_nxt;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
`endif

  sync_2ff u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .D     (bus.Btn_Async),
    .Q     (sync_in)
  );

  // The counter is cleared on every state entry, so it tops out at CNT_LAST.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pulse_nxt  = 1'b0;
    stable_nxt = stable_q;
`ifdef BTN_AUTO_REPEAT_EN
    rcnt_nxt   = rcnt;
`endif
    case (state)
      ST_IDLE: begin
        if (sync_in) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_in) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = ST_PRESSED;
          cnt_nxt    = '0;
          pulse_nxt  = 1'b1;
          stable_nxt = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          rcnt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!sync_in) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rcnt_nxt  = '0;
`endif
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (rcnt == RPT_LAST) begin
            pulse_nxt = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + CNT_ONE;
          end
`endif
        end
      end
      ST_RELEASE_WAIT: begin
        // A press seen here is release bounce (or a button held through reset):
        // return to PRESSED silently.
        if (sync_in) begin
          state_nxt  = ST_PRESSED;
          cnt_nxt    = '0;
          stable_nxt = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          rcnt_nxt   = '0;
`endif
        end else if (cnt == CNT_LAST) begin
          state_nxt  = ST_IDLE;
          cnt_nxt    = '0;
          stable_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_RELEASE_WAIT;
      cnt      <= '0;
      pulse_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pulse_q  <= pulse_nxt;
      stable_q <= stable_nxt;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt_nxt;
    end
  end
`endif

  assign bus.Pulse     = pulse_q;
  assign bus.Stable    = stable_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: directed latency/bounce/reset scenarios plus a
// randomized run checked against a run-length reference model.
module tb_button_debounce_pulse;
  import btn_pkg::*;

  localparam int D  = 4;
  localparam int R  = 8;
  localparam int CW = 5;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  button_debounce_pulse_if bus ();

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW),
    .REPEAT_CYCLES   (R)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  task automatic do_reset(input int n);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (n) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic settle();
    bus.Btn_Async = 1'b0;
    repeat (D + 5) @(negedge Clk);
  endtask

  // ---------------- reference model ----------------
  // A level change is accepted once the synchronized input has disagreed with
  // the accepted level for D+1 consecutive samples. After reset the level is
  // provisional: any press sample makes it pressed, D release samples make it idle.
  logic m_s1, m_s2, m_level, m_pulse, m_hold, m_samp;
  int   m_run, m_zeros, m_held;

  always @(posedge Clk) begin
    if (Reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_pulse = 1'b0;
      m_hold = 1'b1; m_run = 0; m_zeros = 0; m_held = 0;
    end else begin
      m_samp  = m_s2;
      m_s2    = m_s1;
      m_s1    = bus.Btn_Async;
      m_pulse = 1'b0;
      if (m_hold) begin
        if (m_samp) begin
          m_hold = 1'b0; m_level = 1'b1; m_held = 0;
        end else begin
          m_zeros++;
          if (m_zeros == D) begin m_hold = 1'b0; m_level = 1'b0; end
        end
      end else if (m_samp == m_level) begin
        if (m_level && m_run == 0) begin
          if (AUTO && m_held == R - 1) begin m_pulse = 1'b1; m_held = 0; end
          else m_held++;
        end else begin
          m_held = 0;
        end
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = m_samp; m_run = 0; m_held = 0;
          if (m_samp) m_pulse = 1'b1;
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.Btn_Async = 1'b0;
    do_reset(2);
    checks++;
    if (bus.Pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", bus.Pulse); end
    checks++;
    if (bus.Stable !== 1'b0) begin errors++; $display("FAIL reset_stable: got %b want 0", bus.Stable); end
    checks++;
    if (bus.dbg_state !== ST_RELEASE_WAIT) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_RELEASE_WAIT);
    end
  endtask

  task automatic test_latency();
    logic ep, es;
    settle();
    bus.Btn_Async = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      ep = (k == 7);
      es = (k >= 7);
      checks++;
      if (bus.Pulse !== ep) begin errors++; $display("FAIL latency_pulse edge %0d: got %b want %b", k, bus.Pulse, ep); end
      checks++;
      if (bus.Stable !== es) begin errors++; $display("FAIL latency_stable edge %0d: got %b want %b", k, bus.Stable, es); end
    end
    bus.Btn_Async = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      es = (k < 7);
      checks++;
      if (bus.Stable !== es) begin errors++; $display("FAIL release_stable edge %0d: got %b want %b", k, bus.Stable, es); end
      checks++;
      if (bus.Pulse !== 1'b0) begin errors++; $display("FAIL release_pulse edge %0d: got %b want 0", k, bus.Pulse); end
    end
  endtask

  task automatic test_press_bounce();
    settle();
    for (int k = 0; k < 16; k++) begin
      bus.Btn_Async = (k < 10) ? ((k % 2) == 0) : 1'b0;
      @(negedge Clk);
      checks++;
      if (bus.Pulse !== 1'b0) begin errors++; $display("FAIL press_bounce_pulse cycle %0d: got %b want 0", k, bus.Pulse); end
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL press_bounce_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    checks++;
    if (bus.Stable !== 1'b0) begin errors++; $display("FAIL press_bounce_stable: got %b want 0", bus.Stable); end
  endtask

  task automatic test_release_bounce();
    int pulses = 0;
    settle();
    bus.Btn_Async = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      if (bus.Pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL release_bounce_press: got %0d pulses want 1", pulses); end
    bus.Btn_Async = 1'b0;
    repeat (2) @(negedge Clk);
    bus.Btn_Async = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      checks++;
      if (bus.Stable !== 1'b1) begin errors++; $display("FAIL release_bounce_stable cycle %0d: got %b want 1", k, bus.Stable); end
      checks++;
      if (bus.Pulse !== 1'b0) begin errors++; $display("FAIL release_bounce_pulse cycle %0d: got %b want 0", k, bus.Pulse); end
    end
    settle();
  endtask

  task automatic test_held_through_reset();
    logic es;
    bus.Btn_Async = 1'b1;
    repeat (3) @(negedge Clk);
    do_reset(2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      es = (k >= 3);
      checks++;
      if (bus.Pulse !== 1'b0) begin errors++; $display("FAIL held_reset_pulse edge %0d: got %b want 0", k, bus.Pulse); end
      checks++;
      if (bus.Stable !== es) begin errors++; $display("FAIL held_reset_stable edge %0d: got %b want %b", k, bus.Stable, es); end
    end
    bus.Btn_Async = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      es = (k < 7);
      checks++;
      if (bus.Stable !== es) begin errors++; $display("FAIL held_release_stable edge %0d: got %b want %b", k, bus.Stable, es); end
    end
  endtask

  task automatic test_reset_mid_press();
    settle();
    bus.Btn_Async = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if (bus.dbg_state !== ST_PRESS_WAIT) begin errors++; $display("FAIL mid_press_state: got %0d want %0d", bus.dbg_state, ST_PRESS_WAIT); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if (bus.Stable !== 1'b0) begin errors++; $display("FAIL mid_press_reset_stable: got %b want 0", bus.Stable); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      checks++;
      if (bus.Pulse !== 1'b0) begin errors++; $display("FAIL mid_press_pulse edge %0d: got %b want 0", k, bus.Pulse); end
    end
    checks++;
    if (bus.Stable !== 1'b1) begin errors++; $display("FAIL mid_press_held_stable: got %b want 1", bus.Stable); end
    settle();
  endtask

  task automatic test_hold_long();
    logic ep;
    settle();
    exp_q.delete();
    exp_q.push_back(8'd7);
    if (AUTO) begin
      exp_q.push_back(8'd15);
      exp_q.push_back(8'd23);
      exp_q.push_back(8'd31);
    end
    bus.Btn_Async = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge Clk);
      ep = (exp_q.size() > 0 && exp_q[0] == 8'(k));
      if (ep) void'(exp_q.pop_front());
      checks++;
      if (bus.Pulse !== ep) begin errors++; $display("FAIL hold_long_pulse edge %0d: got %b want %b", k, bus.Pulse, ep); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL hold_long_missing: got %0d pulses left want 0", exp_q.size()); end
    settle();
  endtask

  task automatic test_random();
    logic lvl, prev_pulse, rst_now;
    int   seg_len;
    prev_pulse = 1'b0;
    for (int seg = 0; seg < 300; seg++) begin
      lvl     = 1'($urandom_range(0, 1));
      seg_len = ($urandom_range(0, 3) == 0) ? $urandom_range(D + 1, 3 * R) : $urandom_range(1, D + 2);
      rst_now = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < seg_len; c++) begin
        bus.Btn_Async = lvl;
        Reset = rst_now && (c == 0);
        @(negedge Clk);
        checks++;
        if (bus.Pulse !== m_pulse) begin errors++; $display("FAIL random_pulse seg %0d: got %b want %b", seg, bus.Pulse, m_pulse); end
        checks++;
        if (bus.Stable !== m_level) begin errors++; $display("FAIL random_stable seg %0d: got %b want %b", seg, bus.Stable, m_level); end
        checks++;
        if (prev_pulse === 1'b1 && bus.Pulse === 1'b1) begin errors++; $display("FAIL random_back_to_back seg %0d: got 1 want 0", seg); end
        prev_pulse = bus.Pulse;
      end
    end
    Reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Reset         = 1'b1;
    bus.Btn_Async = 1'b0;
    test_reset();
    test_latency();
    test_press_bounce();
    test_release_bounce();
    test_held_through_reset();
    test_reset_mid_press();
    test_hold_long();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
